// File: rtl/operator_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | operator_sequencer_pkg: shared types and constants for the sequencer slice |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package operator_sequencer_pkg;

  typedef logic [7:0] VoiceOperatorID_t;

  localparam int DEFAULT_NUM_VOICE_OPERATORS = 96;
  localparam int DEFAULT_RESULT_TIMEOUT      = 16;

  // Downstream stages compare the slot ID against this to detect end of frame.
  localparam VoiceOperatorID_t VOICE_OPERATOR_FRAME_END = 8'hff;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    SENTINEL = 2'd2,
    WAIT     = 2'd3
  } SequencerState_t;

  // Sticky flag update where a same-cycle set beats a clear.
  function automatic logic flag_next(input logic set, input logic clear, input logic q);
    return set | (q & ~clear);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_handoff_register.sv
// +----------------------------------------------------------------------------+
// | sample_handoff_register: holds the frame sample under a valid/ack handshake |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sample_handoff_register
  import operator_sequencer_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               capture_i,
  input  logic signed [15:0] sample_i,
  input  logic               ack_i,
  input  logic               clear_i,
  output logic signed [15:0] sample_o,
  output logic               valid_o,
  output logic               dropped_o
);

  logic signed [15:0] sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               dropped_q, dropped_d;
  logic               drop_set;

  always_comb begin
    sample_d = sample_q;
    valid_d  = valid_q;
    // An ack in the capture cycle consumes the old sample, so nothing is lost.
    drop_set = capture_i & valid_q & ~ack_i;
    if (capture_i) begin
      sample_d = sample_i;
      valid_d  = 1'b1;
    end else if (ack_i) begin
      valid_d  = 1'b0;
    end
    dropped_d = flag_next(drop_set, clear_i, dropped_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q  <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign sample_o  = sample_q;
  assign valid_o   = valid_q;
  assign dropped_o = dropped_q;

endmodule

`default_nettype wire

// File: rtl/operator_sequencer.sv
// +----------------------------------------------------------------------------+
// | operator_sequencer: per-sample slot scheduler, frame sentinel, result wait |
// | Optional macro SEQUENCER_OVERRUN_COUNT_EN adds o_OverrunCount.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module operator_sequencer
  import operator_sequencer_pkg::*;
#(
  parameter int NUM_VOICE_OPERATORS = DEFAULT_NUM_VOICE_OPERATORS,
  parameter int RESULT_TIMEOUT      = DEFAULT_RESULT_TIMEOUT
) (
  input  logic               i_Clock,
  input  logic               i_Reset_n,
  input  logic               i_SampleTick,
  output logic [7:0]         o_VoiceOperator,
  output logic               o_OperatorValid,
  output logic               o_FrameEnd,
  input  logic               i_SampleReady,
  input  logic signed [15:0] i_Sample,
  output logic signed [15:0] o_Sample,
  output logic               o_SampleValid,
  input  logic               i_SampleAck,
  output logic               o_Busy,
  output logic               o_Overrun,
  output logic               o_Timeout,
  output logic               o_SampleDropped,
`ifdef SEQUENCER_OVERRUN_COUNT_EN
  output logic [15:0]        o_OverrunCount,
`endif
  input  logic               i_ClearStatus
);

  localparam int WAIT_W = $clog2(RESULT_TIMEOUT + 1);
  localparam VoiceOperatorID_t  LAST_SLOT = VoiceOperatorID_t'(NUM_VOICE_OPERATORS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RESULT_TIMEOUT - 1);

  SequencerState_t   state_q, state_d;
  VoiceOperatorID_t  slot_q, slot_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  VoiceOperatorID_t  vop_q, vop_d;
  logic              opvalid_q, opvalid_d;
  logic              frameend_q, frameend_d;

  logic              capture;
  logic              tick_drop;
  logic              timeout_set;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    wait_d      = wait_q;
    pending_d   = pending_q;
    capture     = 1'b0;
    tick_drop   = 1'b0;
    timeout_set = 1'b0;

    // One tick can be queued while busy; a second one is lost.
    if (i_SampleTick && (state_q != IDLE)) begin
      if (pending_q) tick_drop = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_SampleTick || pending_q) begin
          state_d   = RUN;
          slot_d    = '0;
          pending_d = 1'b0;
        end
      end
      RUN: begin
        if (slot_q == LAST_SLOT) state_d = SENTINEL;
        else                     slot_d  = slot_q + 8'd1;
      end
      SENTINEL: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        if (i_SampleReady) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (wait_q == LAST_WAIT) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    overrun_d = flag_next(tick_drop, i_ClearStatus, overrun_q);
    timeout_d = flag_next(timeout_set, i_ClearStatus, timeout_q);

    // Slot outputs are decoded from the next state so they leave a register.
    vop_d      = VOICE_OPERATOR_FRAME_END;
    opvalid_d  = 1'b0;
    frameend_d = 1'b0;
    case (state_d)
      RUN: begin
        vop_d     = slot_d;
        opvalid_d = 1'b1;
      end
      SENTINEL: frameend_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      wait_q     <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      vop_q      <= VOICE_OPERATOR_FRAME_END;
      opvalid_q  <= 1'b0;
      frameend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      wait_q     <= wait_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      vop_q      <= vop_d;
      opvalid_q  <= opvalid_d;
      frameend_q <= frameend_d;
    end
  end

`ifdef SEQUENCER_OVERRUN_COUNT_EN
  logic [15:0] overrun_count_q, overrun_count_d;

  always_comb begin
    overrun_count_d = overrun_count_q;
    if (tick_drop) begin
      if (overrun_count_q != 16'hffff) overrun_count_d = overrun_count_q + 16'd1;
    end else if (i_ClearStatus) begin
      overrun_count_d = '0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) overrun_count_q <= '0;
    else            overrun_count_q <= overrun_count_d;
  end

  assign o_OverrunCount = overrun_count_q;
`else
  // Without the counter, the sticky o_Overrun is the only record of dropped ticks.
`endif

  sample_handoff_register u_handoff (
    .clk_i     (i_Clock),
    .rst_ni    (i_Reset_n),
    .capture_i (capture),
    .sample_i  (i_Sample),
    .ack_i     (i_SampleAck),
    .clear_i   (i_ClearStatus),
    .sample_o  (o_Sample),
    .valid_o   (o_SampleValid),
    .dropped_o (o_SampleDropped)
  );

  assign o_VoiceOperator = vop_q;
  assign o_OperatorValid = opvalid_q;
  assign o_FrameEnd      = frameend_q;
  assign o_Busy          = (state_q != IDLE);
  assign o_Overrun       = overrun_q;
  assign o_Timeout       = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_operator_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_operator_sequencer: scoreboard bench for operator_sequencer             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_operator_sequencer;

  localparam int N = 96;

  logic        i_Clock = 1'b0;
  logic        i_Reset_n = 1'b0;
  logic        i_SampleTick = 1'b0;
  logic        i_SampleReady = 1'b0;
  logic [15:0] i_Sample = '0;
  logic        i_SampleAck = 1'b0;
  logic        i_ClearStatus = 1'b0;
  logic [7:0]  o_VoiceOperator;
  logic        o_OperatorValid;
  logic        o_FrameEnd;
  logic [15:0] o_Sample;
  logic        o_SampleValid;
  logic        o_Busy;
  logic        o_Overrun;
  logic        o_Timeout;
  logic        o_SampleDropped;
`ifdef SEQUENCER_OVERRUN_COUNT_EN
  logic [15:0] o_OverrunCount;
`endif

  int checks = 0;
  int errors = 0;

  logic [9:0]  exp_ops[$];
  logic [15:0] exp_samples[$];

  operator_sequencer dut (
    .i_Clock         (i_Clock),
    .i_Reset_n       (i_Reset_n),
    .i_SampleTick    (i_SampleTick),
    .o_VoiceOperator (o_VoiceOperator),
    .o_OperatorValid (o_OperatorValid),
    .o_FrameEnd      (o_FrameEnd),
    .i_SampleReady   (i_SampleReady),
    .i_Sample        (i_Sample),
    .o_Sample        (o_Sample),
    .o_SampleValid   (o_SampleValid),
    .i_SampleAck     (i_SampleAck),
    .o_Busy          (o_Busy),
    .o_Overrun       (o_Overrun),
    .o_Timeout       (o_Timeout),
    .o_SampleDropped (o_SampleDropped),
`ifdef SEQUENCER_OVERRUN_COUNT_EN
    .o_OverrunCount  (o_OverrunCount),
`endif
    .i_ClearStatus   (i_ClearStatus)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected slot stream and consumed samples as the DUT presents them.
  always @(negedge i_Clock) begin
    if (i_Reset_n && (o_OperatorValid || o_FrameEnd)) begin
      if (exp_ops.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL op_stream: got unexpected slot %0h expected none", o_VoiceOperator);
      end else begin
        check("op_stream", 32'({o_FrameEnd, o_OperatorValid, o_VoiceOperator}),
              32'(exp_ops.pop_front()));
      end
    end
    if (i_Reset_n && o_SampleValid && i_SampleAck) begin
      if (exp_samples.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample_stream: got unexpected sample %0h expected none", o_Sample);
      end else begin
        check("sample_stream", 32'(o_Sample), 32'(exp_samples.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) exp_ops.push_back({1'b0, 1'b1, 8'(i)});
    exp_ops.push_back({1'b1, 1'b0, 8'hff});
  endtask

  task automatic frame_start();
    i_SampleTick = 1'b1;
    push_frame();
    step();
    i_SampleTick = 1'b0;
  endtask

  task automatic wait_sentinel(output int n);
    n = 0;
    while (!o_FrameEnd && n < 300) begin
      step();
      n++;
    end
    check("sentinel_seen", 32'(o_FrameEnd), 32'd1);
  endtask

  task automatic give_sample(input logic [15:0] val, input int delay, input bit ack_too);
    repeat (delay) step();
    i_SampleReady = 1'b1;
    i_Sample      = val;
    i_SampleAck   = ack_too;
    step();
    i_SampleReady = 1'b0;
    i_SampleAck   = 1'b0;
  endtask

  task automatic ack_pulse(input logic [15:0] val);
    exp_samples.push_back(val);
    i_SampleAck = 1'b1;
    step();
    i_SampleAck = 1'b0;
  endtask

  task automatic clear_status();
    i_ClearStatus = 1'b1;
    step();
    i_ClearStatus = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Reset state
    repeat (3) step();
    check("rst_vop", 32'(o_VoiceOperator), 32'hff);
    check("rst_opvalid", 32'(o_OperatorValid), 32'd0);
    check("rst_frameend", 32'(o_FrameEnd), 32'd0);
    check("rst_svalid", 32'(o_SampleValid), 32'd0);
    check("rst_sample", 32'(o_Sample), 32'd0);
    check("rst_flags", 32'({o_Overrun, o_Timeout, o_SampleDropped}), 32'd0);
    check("rst_busy", 32'(o_Busy), 32'd0);
    i_Reset_n = 1'b1;
    step();

    // 1: slot walk latency
    frame_start();
    check("t1_slot0", 32'(o_VoiceOperator), 32'd0);
    check("t1_slot0_valid", 32'(o_OperatorValid), 32'd1);
    check("t1_busy", 32'(o_Busy), 32'd1);
    wait_sentinel(n);
    check("t1_sentinel_latency", 32'(n), 32'd96);
    check("t1_sentinel_id", 32'(o_VoiceOperator), 32'hff);

    // 2: result four clocks after the sentinel
    give_sample(16'h1234, 4, 1'b0);
    check("t2_sample", 32'(o_Sample), 32'h1234);
    check("t2_svalid", 32'(o_SampleValid), 32'd1);
    check("t2_busy", 32'(o_Busy), 32'd0);
    ack_pulse(16'h1234);
    check("t2_svalid_acked", 32'(o_SampleValid), 32'd0);

    // 3: pending tick and overrun
    frame_start();
    push_frame();
    repeat (10) step();
    i_SampleTick = 1'b1;
    step();
    i_SampleTick = 1'b0;
    repeat (5) step();
    check("t3_no_overrun_yet", 32'(o_Overrun), 32'd0);
    i_SampleTick = 1'b1;
    step();
    i_SampleTick = 1'b0;
    check("t3_overrun", 32'(o_Overrun), 32'd1);
`ifdef SEQUENCER_OVERRUN_COUNT_EN
    check("t3_overrun_count", 32'(o_OverrunCount), 32'd1);
`endif
    wait_sentinel(n);
    give_sample(16'h5a5a, 2, 1'b0);
    check("t3_idle_gap_busy", 32'(o_Busy), 32'd0);
    check("t3_idle_gap_opvalid", 32'(o_OperatorValid), 32'd0);
    ack_pulse(16'h5a5a);
    check("t3_restart_slot", 32'(o_VoiceOperator), 32'd0);
    check("t3_restart_valid", 32'(o_OperatorValid), 32'd1);
    wait_sentinel(n);
    check("t3_frame2_latency", 32'(n), 32'd96);
    give_sample(16'h0102, 1, 1'b0);
    ack_pulse(16'h0102);
    clear_status();
    check("t3_overrun_cleared", 32'(o_Overrun), 32'd0);
`ifdef SEQUENCER_OVERRUN_COUNT_EN
    check("t3_count_cleared", 32'(o_OverrunCount), 32'd0);
`endif

    // 4: result timeout
    frame_start();
    wait_sentinel(n);
    repeat (16) step();
    check("t4_still_waiting", 32'(o_Busy), 32'd1);
    check("t4_no_timeout_yet", 32'(o_Timeout), 32'd0);
    step();
    check("t4_timeout", 32'(o_Timeout), 32'd1);
    check("t4_idle", 32'(o_Busy), 32'd0);
    check("t4_no_capture", 32'(o_SampleValid), 32'd0);
    clear_status();
    check("t4_timeout_cleared", 32'(o_Timeout), 32'd0);

    // 5: overwrite without ack, then ack coincident with capture
    frame_start();
    wait_sentinel(n);
    give_sample(16'haaaa, 1, 1'b0);
    frame_start();
    wait_sentinel(n);
    give_sample(16'hbbbb, 1, 1'b0);
    check("t5_dropped", 32'(o_SampleDropped), 32'd1);
    check("t5_second_value", 32'(o_Sample), 32'hbbbb);
    ack_pulse(16'hbbbb);
    clear_status();
    check("t5_dropped_cleared", 32'(o_SampleDropped), 32'd0);
    frame_start();
    wait_sentinel(n);
    give_sample(16'hcccc, 1, 1'b0);
    exp_samples.push_back(16'hcccc);
    frame_start();
    wait_sentinel(n);
    give_sample(16'hdddd, 1, 1'b1);
    check("t5_coincident_no_drop", 32'(o_SampleDropped), 32'd0);
    check("t5_coincident_value", 32'(o_Sample), 32'hdddd);
    check("t5_coincident_valid", 32'(o_SampleValid), 32'd1);
    ack_pulse(16'hdddd);

    // 6: asynchronous reset mid-RUN
    frame_start();
    repeat (40) step();
    check("t6_slot40", 32'(o_VoiceOperator), 32'd40);
    #2 i_Reset_n = 1'b0;
    #1;
    check("t6_async_vop", 32'(o_VoiceOperator), 32'hff);
    check("t6_async_opvalid", 32'(o_OperatorValid), 32'd0);
    check("t6_async_busy", 32'(o_Busy), 32'd0);
    check("t6_async_sample", 32'(o_Sample), 32'd0);
    exp_ops.delete();
    repeat (2) step();
    i_Reset_n = 1'b1;
    step();
    i_SampleReady = 1'b1;
    i_Sample      = 16'h7777;
    step();
    i_SampleReady = 1'b0;
    step();
    check("t6_no_sample", 32'(o_SampleValid), 32'd0);
    check("t6_idle", 32'(o_Busy), 32'd0);

    check("ops_drained", 32'(exp_ops.size()), 32'd0);
    check("samples_drained", 32'(exp_samples.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
